mini_cpu_ctrl: RTL and testbench

//  Instruction sequencer for the Mini-CPU 16x16 register RAM. Accepts one decoded instruction
//  (opcode, three 4-bit addresses, immediate) per handshake and drives the RAM read/write ports.

---
 rtl/mini_cpu_ctrl_pkg.sv | 45 ++++
 rtl/mini_cpu_ctrl_if.sv | 50 +++++
 rtl/mini_cpu_ctrl_alu.sv | 64 ++++++
 rtl/mini_cpu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mini_cpu_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mini_cpu_ctrl_pkg.sv
// Shared types and widths for the Mini-CPU instruction sequencer.
//   DATA_W / ADDR_W / DEPTH : RAM word width, address width, word count
//   opcode_e                : instruction opcodes as seen on the decoder bus
//   state_e                 : sequencer FSM states
//   instr_t                 : latched instruction payload
// Optional feature macro used by the including files: MINI_CPU_OVF_EN.
package mini_cpu_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_ADD     = 3'b001,
    OP_ADDI    = 3'b010,
    OP_SUB     = 3'b011,
    OP_SUBI    = 3'b100,
    OP_MUL     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_DISPLAY = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WB   = 3'd2,
    ST_CLR  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef struct packed {
    opcode_e             opcode;
    logic [ADDR_W-1:0]   addr1;
    logic [ADDR_W-1:0]   addr2;
    logic [ADDR_W-1:0]   addr3;
    logic [DATA_W-1:0]   imm;
  } instr_t;

  // Register-register ops take their second operand from read port 2.
  function automatic logic uses_rs2(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mini_cpu_ctrl_if.sv
// Instruction handshake + RAM port bundle for the Mini-CPU sequencer.
//   slave  : the sequencer (accepts instructions, drives RAM read/write ports)
//   master : decoder front-end + RAM bank side
// Signals: instr_valid/ready, opcode, addr1..3, imm, mem_raddr1/2, mem_rdata1/2,
//   mem_we/waddr/wdata, disp_val, done, and ovf when MINI_CPU_OVF_EN is defined.
interface mini_cpu_ctrl_if;
  import mini_cpu_ctrl_pkg::*;

  logic                instr_valid;
  logic                instr_ready;
  opcode_e             opcode;
  logic [ADDR_W-1:0]   addr1;
  logic [ADDR_W-1:0]   addr2;
  logic [ADDR_W-1:0]   addr3;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   mem_raddr1;
  logic [ADDR_W-1:0]   mem_raddr2;
  logic [DATA_W-1:0]   mem_rdata1;
  logic [DATA_W-1:0]   mem_rdata2;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   disp_val;
  logic                done;
`ifdef MINI_CPU_OVF_EN
  logic                ovf;

  modport slave (
    input  instr_valid, opcode, addr1, addr2, addr3, imm, mem_rdata1, mem_rdata2,
    output instr_ready, mem_raddr1, mem_raddr2, mem_we, mem_waddr, mem_wdata,
           disp_val, done, ovf
  );
  modport master (
    output instr_valid, opcode, addr1, addr2, addr3, imm, mem_rdata1, mem_rdata2,
    input  instr_ready, mem_raddr1, mem_raddr2, mem_we, mem_waddr, mem_wdata,
           disp_val, done, ovf
  );
`else
  modport slave (
    input  instr_valid, opcode, addr1, addr2, addr3, imm, mem_rdata1, mem_rdata2,
    output instr_ready, mem_raddr1, mem_raddr2, mem_we, mem_waddr, mem_wdata,
           disp_val, done
  );
  modport master (
    output instr_valid, opcode, addr1, addr2, addr3, imm, mem_rdata1, mem_rdata2,
    input  instr_ready, mem_raddr1, mem_raddr2, mem_we, mem_waddr, mem_wdata,
           disp_val, done
  );
`endif
endinterface

// File: rtl/mini_cpu_ctrl_alu.sv
// Combinational ALU for the Mini-CPU sequencer.
//   i_op       : opcode selecting add / sub / mul
//   i_a, i_b   : DATA_W operands
//   o_result_c : result modulo 2**DATA_W
//   o_ovf_c    : signed overflow (only when MINI_CPU_OVF_EN is defined)
module mini_cpu_ctrl_alu
  import mini_cpu_ctrl_pkg::*;
(
  input  opcode_e            i_op,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
`ifdef MINI_CPU_OVF_EN
  output logic               o_ovf_c,
`endif
  output logic [DATA_W-1:0]  o_result_c
);

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_mul;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

`ifdef MINI_CPU_OVF_EN
  // Sign-extended full-width product; low 2*DATA_W bits equal the signed product.
  logic [2*DATA_W-1:0] w_prod;
  assign w_prod = {{DATA_W{i_a[DATA_W-1]}}, i_a} * {{DATA_W{i_b[DATA_W-1]}}, i_b};
  assign w_mul  = w_prod[DATA_W-1:0];
`else
  assign w_mul  = i_a * i_b;
`endif

  // Result select (and overflow classification when enabled).
  always_comb begin
    o_result_c = '0;
`ifdef MINI_CPU_OVF_EN
    o_ovf_c    = 1'b0;
`endif
    case (i_op)
      OP_ADD, OP_ADDI: begin
        o_result_c = w_sum;
`ifdef MINI_CPU_OVF_EN
        o_ovf_c = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1] != i_a[DATA_W-1]);
`endif
      end
      OP_SUB, OP_SUBI: begin
        o_result_c = w_diff;
`ifdef MINI_CPU_OVF_EN
        o_ovf_c = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);
`endif
      end
      OP_MUL: begin
        o_result_c = w_mul;
`ifdef MINI_CPU_OVF_EN
        // Representable only if bits [2W-1:W-1] are all copies of the sign bit.
        o_ovf_c = (w_prod[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){w_prod[DATA_W-1]}});
`endif
      end
      default: o_result_c = '0;
    endcase
  end

endmodule

// File: rtl/mini_cpu_ctrl.sv
// Mini-CPU instruction sequencer: accepts one decoded instruction per handshake,
// reads operands from the 16x16 register RAM, computes through the ALU, writes
// back and pulses done. CLEAR zeroes all 16 words, DISPLAY latches disp_val.
// Ports: clk, rst_n (async, active-low), bus (mini_cpu_ctrl_if.slave).
// Optional feature: MINI_CPU_OVF_EN adds bus.ovf (signed overflow of last ALU op).
module mini_cpu_ctrl
  import mini_cpu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mini_cpu_ctrl_if.slave bus
);

  state_e             r_state,  w_state_nxt;
  instr_t             r_instr,  w_instr_nxt;
  logic [ADDR_W-1:0]  r_raddr2, w_raddr2_nxt;
  logic               r_we,     w_we_nxt;
  logic [ADDR_W-1:0]  r_waddr,  w_waddr_nxt;
  logic [DATA_W-1:0]  r_wdata,  w_wdata_nxt;
  logic [DATA_W-1:0]  r_disp,   w_disp_nxt;
  logic               r_done;
  logic               r_ready;

  logic [DATA_W-1:0]  w_alu_b;
  logic [DATA_W-1:0]  w_alu_res;

`ifdef MINI_CPU_OVF_EN
  logic               r_ovf, w_ovf_nxt;
  logic               w_alu_ovf;
`endif

  assign w_alu_b = uses_rs2(r_instr.opcode) ? bus.mem_rdata2 : r_instr.imm;

  mini_cpu_ctrl_alu u_alu (
    .i_op       (r_instr.opcode),
    .i_a        (bus.mem_rdata1),
    .i_b        (w_alu_b),
`ifdef MINI_CPU_OVF_EN
    .o_ovf_c    (w_alu_ovf),
`endif
    .o_result_c (w_alu_res)
  );

  // Next-state and next-output logic; write strobes are registered so they
  // appear in the cycle after they are computed (WB for ALU ops).
  always_comb begin
    w_state_nxt  = r_state;
    w_instr_nxt  = r_instr;
    w_raddr2_nxt = r_raddr2;
    w_we_nxt     = 1'b0;
    w_waddr_nxt  = r_waddr;
    w_wdata_nxt  = r_wdata;
    w_disp_nxt   = r_disp;
`ifdef MINI_CPU_OVF_EN
    w_ovf_nxt    = r_ovf;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          w_instr_nxt = '{opcode: bus.opcode, addr1: bus.addr1, addr2: bus.addr2,
                          addr3: bus.addr3, imm: bus.imm};
          case (bus.opcode)
            OP_LOAD: begin
              w_state_nxt = ST_WB;
              w_we_nxt    = 1'b1;
              w_waddr_nxt = bus.addr1;
              w_wdata_nxt = bus.imm;
            end
            OP_CLEAR: begin
              w_state_nxt = ST_CLR;
              w_we_nxt    = 1'b1;
              w_waddr_nxt = '0;
              w_wdata_nxt = '0;
            end
            default: begin
              w_state_nxt  = ST_RD;
              w_raddr2_nxt = uses_rs2(bus.opcode) ? bus.addr2 : '0;
            end
          endcase
        end
      end
      ST_RD: begin
        // Read data for the latched addresses is valid in this cycle.
        w_state_nxt = ST_WB;
        case (r_instr.opcode)
          OP_DISPLAY: w_disp_nxt = bus.mem_rdata1;
          OP_ADD, OP_SUB: begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_instr.addr3;
            w_wdata_nxt = w_alu_res;
`ifdef MINI_CPU_OVF_EN
            w_ovf_nxt   = w_alu_ovf;
`endif
          end
          default: begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_instr.addr2;
            w_wdata_nxt = w_alu_res;
`ifdef MINI_CPU_OVF_EN
            w_ovf_nxt   = w_alu_ovf;
`endif
          end
        endcase
      end
      ST_WB:   w_state_nxt = ST_DONE;
      ST_CLR: begin
        // r_waddr doubles as the CLEAR sweep counter.
        if (r_waddr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_waddr + ADDR_W'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_instr  <= '0;
      r_raddr2 <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_disp   <= '0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
`ifdef MINI_CPU_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_instr  <= w_instr_nxt;
      r_raddr2 <= w_raddr2_nxt;
      r_we     <= w_we_nxt;
      r_waddr  <= w_waddr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_disp   <= w_disp_nxt;
      r_done   <= (w_state_nxt == ST_DONE);
      r_ready  <= (w_state_nxt == ST_IDLE);
`ifdef MINI_CPU_OVF_EN
      r_ovf    <= w_ovf_nxt;
`endif
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.mem_raddr1  = r_instr.addr1;
  assign bus.mem_raddr2  = r_raddr2;
  assign bus.mem_we      = r_we;
  assign bus.mem_waddr   = r_waddr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.disp_val    = r_disp;
  assign bus.done        = r_done;
`ifdef MINI_CPU_OVF_EN
  assign bus.ovf         = r_ovf;
`endif

endmodule

// File: tb/tb_mini_cpu_ctrl.sv
// Directed bench for mini_cpu_ctrl with a behavioural 16x16 RAM.
module tb_mini_cpu_ctrl;
  import mini_cpu_ctrl_pkg::*;

  logic clk;
  logic rst_n;

  mini_cpu_ctrl_if bus ();

  mini_cpu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [15:0] ram [16];

  assign bus.mem_rdata1 = ram[bus.mem_raddr1];
  assign bus.mem_rdata2 = ram[bus.mem_raddr2];

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_waddr] <= bus.mem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests;
  int unsigned n_fail;

  int unsigned wr_cnt, wr_cyc, done_cyc, acc_wait;
  logic [3:0]  wr_first, wr_last_addr;
  logic [15:0] wr_last_data, wr_data_or;
  logic        wr_asc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ready at a falling edge, then presents one instruction.
  task automatic issue(input opcode_e op, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] a3, input logic [15:0] im);
    acc_wait = 0;
    while (bus.instr_ready !== 1'b1 && acc_wait < 50) begin
      @(negedge clk);
      acc_wait++;
    end
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.addr1       = a1;
    bus.addr2       = a2;
    bus.addr3       = a3;
    bus.imm         = im;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  // Issues an instruction and records writes until done (cycle 1 = first cycle after accept).
  task automatic run(input opcode_e op, input logic [3:0] a1, input logic [3:0] a2,
                     input logic [3:0] a3, input logic [15:0] im, input bit noise);
    issue(op, a1, a2, a3, im);
    wr_cnt = 0; wr_cyc = 0; done_cyc = 0; wr_asc = 1'b1; wr_data_or = '0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.mem_we === 1'b1) begin
        if (wr_cnt == 0) begin
          wr_cyc   = n;
          wr_first = bus.mem_waddr;
        end else if (bus.mem_waddr !== 4'(wr_last_addr + 4'd1)) begin
          wr_asc = 1'b0;
        end
        wr_last_addr = bus.mem_waddr;
        wr_last_data = bus.mem_wdata;
        wr_data_or   = wr_data_or | bus.mem_wdata;
        wr_cnt++;
      end
      if (bus.done === 1'b1) begin
        done_cyc = n;
        break;
      end
      // Noise: LOAD requests that must be ignored while busy.
      bus.instr_valid = noise && n[0];
      bus.opcode      = OP_LOAD;
      bus.addr1       = 4'd9;
      bus.imm         = 16'hDEAD;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
  endtask

  task automatic chk_run(input string tag, input int unsigned lat, input int unsigned wcyc,
                         input logic [3:0] addr, input logic [15:0] data);
    check({tag, "_lat"},  done_cyc, lat);
    check({tag, "_nwr"},  wr_cnt,   (wcyc == 0) ? 0 : 1);
    if (wcyc != 0) begin
      check({tag, "_wcyc"},  wr_cyc,       wcyc);
      check({tag, "_waddr"}, wr_last_addr, addr);
      check({tag, "_wdata"}, wr_last_data, data);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) ram[i] = 16'h0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode      = OP_LOAD;
    bus.addr1       = '0;
    bus.addr2       = '0;
    bus.addr3       = '0;
    bus.imm         = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", bus.instr_ready, 1);
    check("rst_we",    bus.mem_we,      0);
    check("rst_done",  bus.done,        0);
    check("rst_disp",  bus.disp_val,    0);
    check("rst_waddr", bus.mem_waddr,   0);
`ifdef MINI_CPU_OVF_EN
    check("rst_ovf",   bus.ovf,         0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 5 <- 0x1234: write in cycle 1, done in cycle 2
    run(OP_LOAD, 4'd5, 4'd0, 4'd0, 16'h1234, 1'b0);
    chk_run("load5", 2, 1, 4'd5, 16'h1234);
    @(negedge clk);
    check("done_pulse_1cyc", bus.done, 0);
    check("ready_after_done", bus.instr_ready, 1);

    run(OP_LOAD, 4'd1, 4'd0, 4'd0, 16'hFFFF, 1'b0);
    chk_run("load1", 2, 1, 4'd1, 16'hFFFF);
    run(OP_LOAD, 4'd2, 4'd0, 4'd0, 16'h0002, 1'b0);
    check("b2b_wait", acc_wait, 1);

    // ADD r3 = r1 + r2 wraps to 0x0001
    run(OP_ADD, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0);
    chk_run("add_wrap", 3, 2, 4'd3, 16'h0001);
`ifdef MINI_CPU_OVF_EN
    check("add_wrap_ovf", bus.ovf, 0);
`endif

    // SUBI r4 = r2 - 3 = 0xFFFF
    run(OP_SUBI, 4'd2, 4'd4, 4'd0, 16'h0003, 1'b0);
    chk_run("subi", 3, 2, 4'd4, 16'hFFFF);

    // MUL r7 = low16(0x0100 * 0x0100) = 0
    run(OP_LOAD, 4'd6, 4'd0, 4'd0, 16'h0100, 1'b0);
    run(OP_MUL, 4'd6, 4'd7, 4'd0, 16'h0100, 1'b0);
    chk_run("mul_wrap", 3, 2, 4'd7, 16'h0000);
`ifdef MINI_CPU_OVF_EN
    check("mul_ovf", bus.ovf, 1);
`endif

    // MUL r12 = low16(0x1234 * 0x0010) = 0x2340
    run(OP_MUL, 4'd5, 4'd12, 4'd0, 16'h0010, 1'b0);
    chk_run("mul", 3, 2, 4'd12, 16'h2340);

    // ADDI r13 = r5 + 0x0101
    run(OP_ADDI, 4'd5, 4'd13, 4'd0, 16'h0101, 1'b0);
    chk_run("addi", 3, 2, 4'd13, 16'h1335);

    // 0x7FFF + 1 signed overflow; LOAD keeps ovf
    run(OP_LOAD, 4'd8, 4'd0, 4'd0, 16'h7FFF, 1'b0);
    run(OP_LOAD, 4'd9, 4'd0, 4'd0, 16'h0001, 1'b0);
    run(OP_ADD, 4'd8, 4'd9, 4'd10, 16'h0, 1'b0);
    chk_run("add_ovf", 3, 2, 4'd10, 16'h8000);
`ifdef MINI_CPU_OVF_EN
    check("add_ovf_flag", bus.ovf, 1);
    run(OP_LOAD, 4'd14, 4'd0, 4'd0, 16'h0055, 1'b0);
    check("load_keeps_ovf", bus.ovf, 1);
`endif

    // Same-address source and destination: r3 = r3 + r3
    run(OP_ADD, 4'd3, 4'd3, 4'd3, 16'h0, 1'b0);
    chk_run("add_same", 3, 2, 4'd3, 16'h0002);

    // SUB r11 = r1 - r2 = 0xFFFD
    run(OP_SUB, 4'd1, 4'd2, 4'd11, 16'h0, 1'b0);
    chk_run("sub", 3, 2, 4'd11, 16'hFFFD);
`ifdef MINI_CPU_OVF_EN
    check("sub_ovf", bus.ovf, 0);
`endif

    // DISPLAY r5: no write, disp_val = 0x1234
    run(OP_DISPLAY, 4'd5, 4'd0, 4'd0, 16'h0, 1'b0);
    chk_run("display", 3, 0, 4'd0, 16'h0);
    check("display_val", bus.disp_val, 16'h1234);
    check("ram_r4", ram[4], 16'hFFFF);

    // Reset during WB of an ADD aborts the write
    issue(OP_ADD, 4'd1, 4'd2, 4'd15, 16'h0);
    @(negedge clk);
    check("abort_pre_we", bus.mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ready", bus.instr_ready, 1);
    check("abort_we",    bus.mem_we,      0);
    check("abort_done",  bus.done,        0);
    check("abort_disp",  bus.disp_val,    0);
    @(negedge clk);
    check("abort_nowrite", ram[15], 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_ready", bus.instr_ready, 1);

    // CLEAR with ignored valid pulses: 16 ascending zero writes, done in cycle 17
    run(OP_CLEAR, 4'd0, 4'd0, 4'd0, 16'h0, 1'b1);
    check("clr_lat",   done_cyc, 17);
    check("clr_nwr",   wr_cnt,   16);
    check("clr_wcyc",  wr_cyc,   1);
    check("clr_first", wr_first, 0);
    check("clr_last",  wr_last_addr, 15);
    check("clr_asc",   wr_asc,   1);
    check("clr_data",  wr_data_or, 0);
    @(negedge clk);
    check("clr_ram5",  ram[5],   16'h0);
    check("clr_ram9",  ram[9],   16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
